mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width (memory depth 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYC, default 2, wait states inserted per access (0..15).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 mem_read  input  1  read request strobe from control unit.
REQ-007 mem_write  input  1  write request strobe from control unit.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data, right-aligned.
REQ-010 funct3  input  3  access size: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-011 rdata  output  32  extended load data.
REQ-012 ready  output  1  one-cycle completion pulse.
REQ-013 busy  output  1  high while an access is in progress.
REQ-014 err  output  1  error flag, valid with ready.

Function
REQ-015 SHALL implement FSM IDLE, WAIT, DONE; busy high in WAIT and DONE.
REQ-016 In IDLE, a rising edge with exactly one of mem_read or mem_write high SHALL latch addr, wdata, funct3 and op, load the wait counter with WAIT_CYC, and go to WAIT (DONE if WAIT_CYC=0).
REQ-017 WAIT SHALL decrement the counter each cycle and go to DONE on the cycle the counter is 0.
REQ-018 Latency: request sampled at edge N, ready SHALL be high during cycle N+WAIT_CYC+1 only; DONE always returns to IDLE.
REQ-019 Requests while busy SHALL be ignored, with no queuing.
REQ-020 mem_read and mem_write both high in IDLE SHALL go directly to DONE with err=1, no memory access, and rdata unchanged.
REQ-021 Illegal funct3 (011, 110, 111, or 100/101 on a write) SHALL complete with err=1 and no access.
REQ-022 Word index = addr[ADDR_W+1:2]; higher address bits SHALL be ignored (wrap modulo depth).
REQ-023 Writes SHALL commit on the DONE edge, modifying only the addressed byte lanes (SB: lane addr[1:0]; SH: lane pair addr[1]).
REQ-024 Reads SHALL load rdata on the DONE edge: LB/LH sign-extend, LBU/LHU zero-extend, and LW passes the full word.
REQ-025 rdata SHALL hold its value until the next successful read completes.
REQ-026 A read following a write to the same word SHALL return the written data.

Reset
REQ-027 rst low SHALL force IDLE immediately, with rdata=0, ready=0, busy=0, err=0, and counter=0.
REQ-028 Reset mid-access SHALL abort the access; a pending write SHALL NOT commit.
REQ-029 Memory array contents SHALL NOT be affected by reset.

Configuration
REQ-030 Macro MEM_MISALIGN_TRAP_EN, when defined: a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL complete after normal latency with err=1, no access, and rdata unchanged.
REQ-031 When MEM_MISALIGN_TRAP_EN is undefined: a halfword access SHALL ignore addr[0], a word access SHALL ignore addr[1:0], and misalignment SHALL never set err.

Verification
REQ-032 Reset release, SW 0xDEADBEEF to 0x10, then LW 0x10 -> each ready arrives 3 cycles after its request, rdata=0xDEADBEEF, err=0.
REQ-033 SB 0x80 to 0x13 over word 0x11223344, then LB 0x13 and LBU 0x13 -> LB gives rdata=0xFFFFFF80; LBU gives rdata=0x00000080.
REQ-034 mem_read and mem_write both high -> ready 1 cycle later with err=1 and memory unchanged; a new request while busy -> no second ready.
REQ-035 LW 0x02 -> with MEM_MISALIGN_TRAP_EN, err=1 and rdata unchanged; without it, rdata = word 0 contents and err=0.
REQ-036 rst asserted one cycle after an SW request -> busy=0 immediately and no ready; a later LW to that word returns the old value.
REQ-037 WAIT_CYC=0 with addr 0x400 and ADDR_W=8 -> ready 1 cycle after the request, and the access aliases word 0.

Source files
------------

// File: rtl/mem_responder_if.sv
// Control-unit <-> memory responder bus: request strobes, address/data, size code,
// and the completion/status signals driven back by the responder.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output mem_read, mem_write, addr, wdata, funct3,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata, funct3,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised data memory with fixed wait states, byte/half/word access and load extension.
// Optional MEM_MISALIGN_TRAP_EN flags misaligned halfword/word accesses as errors.
module mem_responder #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned WAIT_CYC = 2
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam int unsigned Depth    = 2 ** ADDR_W;
    localparam logic [3:0]  WaitLoad = 4'(WAIT_CYC);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic              write_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              latch, enter_done, conflict;
    logic              sel_write;
    logic [ADDR_W+1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_funct3;
    logic              legal, misaligned, access_ok, do_write, do_read;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        be;
    logic [31:0]       wlanes, word, rd_ext;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic              unused_addr_bits;

    logic [31:0] mem [Depth];

    // Upper address bits wrap the array and are deliberately dropped.
    assign unused_addr_bits = ^bus.addr[31:ADDR_W+2];

    // In IDLE the access is decided on live inputs so WAIT_CYC=0 and conflicts finish in one cycle.
    always_comb begin
        if (state_q == StIdle) begin
            sel_write  = bus.mem_write;
            sel_addr   = bus.addr[ADDR_W+1:0];
            sel_wdata  = bus.wdata;
            sel_funct3 = bus.funct3;
        end else begin
            sel_write  = write_q;
            sel_addr   = addr_q;
            sel_wdata  = wdata_q;
            sel_funct3 = funct3_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch      = 1'b0;
        enter_done = 1'b0;
        conflict   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.mem_read && bus.mem_write) begin
                    state_d    = StDone;
                    enter_done = 1'b1;
                    conflict   = 1'b1;
                end else if (bus.mem_read || bus.mem_write) begin
                    latch = 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_d    = StDone;
                        enter_done = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d      = 4'd0;
                    state_d    = StDone;
                    enter_done = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (sel_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !sel_write;
            default:                legal = 1'b0;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = ((sel_funct3[1:0] == 2'b01) && sel_addr[0]) ||
                        ((sel_funct3[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign access_ok = enter_done && !conflict && legal && !misaligned;
    assign do_write  = access_ok && sel_write;
    assign do_read   = access_ok && !sel_write;
    assign idx       = sel_addr[ADDR_W+1:2];

    // Store data is replicated across lanes; the byte enables pick which lanes land.
    always_comb begin
        be     = 4'b1111;
        wlanes = sel_wdata;
        case (sel_funct3[1:0])
            2'b00: begin
                be     = 4'b0001 << sel_addr[1:0];
                wlanes = {4{sel_wdata[7:0]}};
            end
            2'b01: begin
                be     = sel_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{sel_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = sel_wdata;
            end
        endcase
    end

    always_comb begin
        word    = mem[idx];
        rd_byte = word[{sel_addr[1:0], 3'b000} +: 8];
        rd_half = sel_addr[1] ? word[31:16] : word[15:0];
        case (sel_funct3)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = word;
        endcase
        rdata_d = do_read ? rd_ext : rdata_q;
        err_d   = enter_done && !access_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            write_q  <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                addr_q   <= bus.addr[ADDR_W+1:0];
                wdata_q  <= bus.wdata;
                funct3_q <= bus.funct3;
                write_q  <= bus.mem_write;
            end
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; the rst gate keeps an aborted access from committing.
    always_ff @(posedge clk) begin
        if (rst && do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = (state_q == StDone);
    assign bus.busy  = (state_q != StIdle);
    assign bus.err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with default wait states, one with WAIT_CYC=0.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr, sel;
    logic [31:0] a, wd;
    logic [2:0]  f;
    int          n_checks = 0;
    int          n_errs   = 0;

    always #5 clk = ~clk;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();

    assign bus0.mem_read  = rd & ~sel;
    assign bus0.mem_write = wr & ~sel;
    assign bus0.addr      = a;
    assign bus0.wdata     = wd;
    assign bus0.funct3    = f;
    assign bus1.mem_read  = rd & sel;
    assign bus1.mem_write = wr & sel;
    assign bus1.addr      = a;
    assign bus1.wdata     = wd;
    assign bus1.funct3    = f;

    mem_responder #(.ADDR_W(8), .WAIT_CYC(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mem_responder #(.ADDR_W(8), .WAIT_CYC(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic        ready_s, err_s;
    logic [31:0] rdata_s;
    assign ready_s = sel ? bus1.ready : bus0.ready;
    assign err_s   = sel ? bus1.err   : bus0.err;
    assign rdata_s = sel ? bus1.rdata : bus0.rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, measure cycles to ready, then check status, data and the single pulse.
    task automatic access(input string tag, input logic s, input logic r, input logic w,
                          input logic [31:0] ad, input logic [31:0] dat, input logic [2:0] fn,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
        int lat;
        @(negedge clk);
        sel = s; rd = r; wr = w; a = ad; wd = dat; f = fn;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        lat = 1;
        while (!ready_s && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "/err"}, {31'd0, err_s}, {31'd0, exp_err});
        check({tag, "/rdata"}, rdata_s, exp_rdata);
        @(posedge clk); #1;
        check({tag, "/pulse"}, {31'd0, ready_s}, 32'd0);
    endtask

    initial begin
        int pulses;
        rst = 1'b0; rd = 1'b0; wr = 1'b0; sel = 1'b0; a = '0; wd = '0; f = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/rdata", bus0.rdata, 32'd0);
        check("rst/ready", {31'd0, bus0.ready}, 32'd0);
        check("rst/busy",  {31'd0, bus0.busy},  32'd0);
        check("rst/err",   {31'd0, bus0.err},   32'd0);
        @(negedge clk) rst = 1'b1;

        access("sw10",  1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 3, 1'b0, 32'h0);
        access("lw10",  1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 3, 1'b0, 32'hDEADBEEF);
        access("sw10b", 1'b0, 1'b0, 1'b1, 32'h10, 32'h11223344, 3'b010, 3, 1'b0, 32'hDEADBEEF);
        access("sb13",  1'b0, 1'b0, 1'b1, 32'h13, 32'h00000080, 3'b000, 3, 1'b0, 32'hDEADBEEF);
        access("lb13",  1'b0, 1'b1, 1'b0, 32'h13, 32'h0,        3'b000, 3, 1'b0, 32'hFFFFFF80);
        access("lbu13", 1'b0, 1'b1, 1'b0, 32'h13, 32'h0,        3'b100, 3, 1'b0, 32'h00000080);
        access("lh12",  1'b0, 1'b1, 1'b0, 32'h12, 32'h0,        3'b001, 3, 1'b0, 32'hFFFF8022);
        access("lhu10", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        3'b101, 3, 1'b0, 32'h00003344);
        access("sh12",  1'b0, 1'b0, 1'b1, 32'h12, 32'h0000A5A5, 3'b001, 3, 1'b0, 32'h00003344);
        access("lw10c", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 3, 1'b0, 32'hA5A53344);

        access("both",  1'b0, 1'b1, 1'b1, 32'h10, 32'h0,        3'b010, 1, 1'b1, 32'hA5A53344);
        access("lw10d", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 3, 1'b0, 32'hA5A53344);
        access("f011",  1'b0, 1'b1, 1'b0, 32'h00, 32'h0,        3'b011, 3, 1'b1, 32'hA5A53344);
        access("sw100", 1'b0, 1'b0, 1'b1, 32'h10, 32'h0,        3'b100, 3, 1'b1, 32'hA5A53344);
        access("lw10e", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 3, 1'b0, 32'hA5A53344);

        access("sw00",  1'b0, 1'b0, 1'b1, 32'h00, 32'h12345678, 3'b010, 3, 1'b0, 32'hA5A53344);
`ifdef MEM_MISALIGN_TRAP_EN
        access("lw02",  1'b0, 1'b1, 1'b0, 32'h02, 32'h0,        3'b010, 3, 1'b1, 32'hA5A53344);
`else
        access("lw02",  1'b0, 1'b1, 1'b0, 32'h02, 32'h0,        3'b010, 3, 1'b0, 32'h12345678);
`endif
        access("wrap",  1'b0, 1'b1, 1'b0, 32'h410, 32'h0,       3'b010, 3, 1'b0, 32'hA5A53344);

        // Second request while busy must be dropped.
        @(negedge clk);
        sel = 1'b0; rd = 1'b1; a = 32'h10; f = 3'b010;
        @(posedge clk); #1;
        rd = 1'b0;
        check("busy/wait", {31'd0, bus0.busy}, 32'd1);
        @(negedge clk);
        rd = 1'b1; a = 32'h00;
        @(posedge clk); #1;
        rd = 1'b0;
        pulses = 0;
        repeat (8) begin
            if (bus0.ready) pulses++;
            @(posedge clk); #1;
        end
        check("busy/pulses", 32'(pulses), 32'd1);
        check("busy/rdata", bus0.rdata, 32'hA5A53344);

        // Reset one cycle into a store aborts it.
        @(negedge clk);
        wr = 1'b1; a = 32'h10; wd = 32'hCAFEF00D; f = 3'b010;
        @(posedge clk); #1;
        wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort/busy",  {31'd0, bus0.busy},  32'd0);
        check("abort/ready", {31'd0, bus0.ready}, 32'd0);
        check("abort/rdata", bus0.rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort/ready2", {31'd0, bus0.ready}, 32'd0);
        @(negedge clk) rst = 1'b1;
        access("lw10f", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 3, 1'b0, 32'hA5A53344);

        access("w0sw", 1'b1, 1'b0, 1'b1, 32'h400, 32'h55AA00FF, 3'b010, 1, 1'b0, 32'h0);
        access("w0lw", 1'b1, 1'b1, 1'b0, 32'h000, 32'h0,        3'b010, 1, 1'b0, 32'h55AA00FF);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
